vga_timing_gen: RTL and testbench

Parametrised, runtime-reconfigurable VGA/video timing generator. It produces pixel/line counters, sync, blank and frame/line-start strobes for the ray-marcher display path. Timing comes from parameter defaults at reset and can be reprogrammed through a valid/ready config port; new timing is applied only at a frame boundary. A configurable output pipeline delays all outputs equally, so they line up with renderer latency.

---
 rtl/vga_timing_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Runtime-reconfigurable video timing generator. A free-running (h,v)
//   counter pair walks the frame described by the live timing registers; the
//   decoded sync/blank/strobe signals pass through PIPE_STAGES registers so
//   that every output lines up with the renderer latency.
//   A new timing set is offered on the cfg_* port with a valid/ready
//   handshake. Legal requests wait in a single pending slot and are swapped
//   into the live registers on the frame wrap edge. Illegal requests are
//   dropped with a one-cycle cfg_err_out pulse.
//
// Ports
//   pixel_clk_in             pixel clock, rising edge
//   rst_n_in                 asynchronous active-low reset
//   cfg_h_*_in / cfg_v_*_in  requested horizontal / vertical timing
//   cfg_valid_in             request valid
//   cfg_ready_out            pending slot is free
//   cfg_err_out              one-cycle pulse: the offered request was rejected
//   hcount_out / vcount_out  pixel / line index
//   hsync_out / vsync_out    syncs, asserted level HSYNC_POL / VSYNC_POL
//   blank_out                1 outside the active area
//   line_start_out           pulse on h==0
//   frame_start_out          pulse on h==0 && v==0
module vga_timing_gen #(
  parameter int H_W         = 11,
  parameter int V_W         = 10,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 11,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 31,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIPE_STAGES = 1
) (
  input  logic           pixel_clk_in,
  input  logic           rst_n_in,
  input  logic [H_W-1:0] cfg_h_active_in,
  input  logic [H_W-1:0] cfg_h_fp_in,
  input  logic [H_W-1:0] cfg_h_sync_in,
  input  logic [H_W-1:0] cfg_h_bp_in,
  input  logic [V_W-1:0] cfg_v_active_in,
  input  logic [V_W-1:0] cfg_v_fp_in,
  input  logic [V_W-1:0] cfg_v_sync_in,
  input  logic [V_W-1:0] cfg_v_bp_in,
  input  logic           cfg_valid_in,
  output logic           cfg_ready_out,
  output logic           cfg_err_out,
  output logic [H_W-1:0] hcount_out,
  output logic [V_W-1:0] vcount_out,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           blank_out,
  output logic           line_start_out,
  output logic           frame_start_out
);

  // Packed output vector: {h, v, hsync, vsync, blank, line_start, frame_start}
  localparam int PW = H_W + V_W + 5;
  localparam logic [PW-1:0] RST_VEC =
    {{H_W{1'b0}}, {V_W{1'b0}}, ~HSYNC_POL, ~VSYNC_POL, 3'b100};

  localparam logic [H_W:0]   H_ONE   = {{H_W{1'b0}}, 1'b1};
  localparam logic [V_W:0]   V_ONE   = {{V_W{1'b0}}, 1'b1};
  localparam logic [H_W-1:0] H_INC   = {{(H_W-1){1'b0}}, 1'b1};
  localparam logic [V_W-1:0] V_INC   = {{(V_W-1){1'b0}}, 1'b1};
  // Largest legal totals: exactly 2^H_W / 2^V_W
  localparam logic [H_W+1:0] H_LIMIT = {2'b01, {H_W{1'b0}}};
  localparam logic [V_W+1:0] V_LIMIT = {2'b01, {V_W{1'b0}}};

  // Live timing
  logic [H_W-1:0] h_active_reg, h_fp_reg, h_sync_reg, h_bp_reg;
  logic [V_W-1:0] v_active_reg, v_fp_reg, v_sync_reg, v_bp_reg;
  // Pending slot
  logic [H_W-1:0] p_h_active_reg, p_h_fp_reg, p_h_sync_reg, p_h_bp_reg;
  logic [V_W-1:0] p_v_active_reg, p_v_fp_reg, p_v_sync_reg, p_v_bp_reg;
  logic           pend_valid_reg;
  logic           cfg_err_reg;
  // Counters
  logic [H_W-1:0] h_reg;
  logic [V_W-1:0] v_reg;

  // Frame geometry from live timing. One extra bit so a total of exactly
  // 2^W does not alias to zero.
  logic [H_W:0] h_total, h_last, hs_start, hs_end;
  logic [V_W:0] v_total, v_last, vs_start, vs_end;

  assign h_total  = {1'b0, h_active_reg} + {1'b0, h_fp_reg} +
                    {1'b0, h_sync_reg} + {1'b0, h_bp_reg};
  assign v_total  = {1'b0, v_active_reg} + {1'b0, v_fp_reg} +
                    {1'b0, v_sync_reg} + {1'b0, v_bp_reg};
  assign h_last   = h_total - H_ONE;
  assign v_last   = v_total - V_ONE;
  assign hs_start = {1'b0, h_active_reg} + {1'b0, h_fp_reg};
  assign hs_end   = hs_start + {1'b0, h_sync_reg};
  assign vs_start = {1'b0, v_active_reg} + {1'b0, v_fp_reg};
  assign vs_end   = vs_start + {1'b0, v_sync_reg};

  logic h_at_end, v_at_end, wrap;
  assign h_at_end = ({1'b0, h_reg} == h_last);
  assign v_at_end = ({1'b0, v_reg} == v_last);
  assign wrap     = h_at_end & v_at_end;

  // Request legality. Totals get two extra bits: four W-bit fields can sum
  // past 2^(W+1), and an overflow here must never look legal.
  logic [H_W+1:0] cfg_h_total;
  logic [V_W+1:0] cfg_v_total;
  logic           cfg_legal, cfg_take;

  assign cfg_h_total = {2'b00, cfg_h_active_in} + {2'b00, cfg_h_fp_in} +
                       {2'b00, cfg_h_sync_in} + {2'b00, cfg_h_bp_in};
  assign cfg_v_total = {2'b00, cfg_v_active_in} + {2'b00, cfg_v_fp_in} +
                       {2'b00, cfg_v_sync_in} + {2'b00, cfg_v_bp_in};
  assign cfg_legal   = (|cfg_h_active_in) & (|cfg_h_sync_in) &
                       (|cfg_v_active_in) & (|cfg_v_sync_in) &
                       (cfg_h_total <= H_LIMIT) & (cfg_v_total <= V_LIMIT);
  assign cfg_take    = cfg_valid_in & ~pend_valid_reg;

  assign cfg_ready_out = ~pend_valid_reg;
  assign cfg_err_out   = cfg_err_reg;

  // Counters
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (h_at_end) begin
      h_reg <= '0;
      v_reg <= v_at_end ? '0 : v_reg + V_INC;
    end else begin
      h_reg <= h_reg + H_INC;
    end
  end

  // Config slot and live timing. A take only happens while the slot is
  // empty, and an apply only while it is full, so the two branches are
  // mutually exclusive. A take on the wrap edge therefore stays pending
  // until the following wrap.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h_active_reg   <= H_W'(H_ACTIVE);
      h_fp_reg       <= H_W'(H_FP);
      h_sync_reg     <= H_W'(H_SYNC);
      h_bp_reg       <= H_W'(H_BP);
      v_active_reg   <= V_W'(V_ACTIVE);
      v_fp_reg       <= V_W'(V_FP);
      v_sync_reg     <= V_W'(V_SYNC);
      v_bp_reg       <= V_W'(V_BP);
      p_h_active_reg <= '0;
      p_h_fp_reg     <= '0;
      p_h_sync_reg   <= '0;
      p_h_bp_reg     <= '0;
      p_v_active_reg <= '0;
      p_v_fp_reg     <= '0;
      p_v_sync_reg   <= '0;
      p_v_bp_reg     <= '0;
      pend_valid_reg <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_take & ~cfg_legal;
      if (wrap && pend_valid_reg) begin
        h_active_reg   <= p_h_active_reg;
        h_fp_reg       <= p_h_fp_reg;
        h_sync_reg     <= p_h_sync_reg;
        h_bp_reg       <= p_h_bp_reg;
        v_active_reg   <= p_v_active_reg;
        v_fp_reg       <= p_v_fp_reg;
        v_sync_reg     <= p_v_sync_reg;
        v_bp_reg       <= p_v_bp_reg;
        pend_valid_reg <= 1'b0;
      end else if (cfg_take && cfg_legal) begin
        p_h_active_reg <= cfg_h_active_in;
        p_h_fp_reg     <= cfg_h_fp_in;
        p_h_sync_reg   <= cfg_h_sync_in;
        p_h_bp_reg     <= cfg_h_bp_in;
        p_v_active_reg <= cfg_v_active_in;
        p_v_fp_reg     <= cfg_v_fp_in;
        p_v_sync_reg   <= cfg_v_sync_in;
        p_v_bp_reg     <= cfg_v_bp_in;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  // Decode of the current counter state
  logic          hsync_act, vsync_act, blank_next;
  logic [PW-1:0] stage_next;

  always_comb begin
    hsync_act  = ({1'b0, h_reg} >= hs_start) && ({1'b0, h_reg} < hs_end);
    vsync_act  = ({1'b0, v_reg} >= vs_start) && ({1'b0, v_reg} < vs_end);
    blank_next = (h_reg >= h_active_reg) || (v_reg >= v_active_reg);
    stage_next = {h_reg, v_reg,
                  hsync_act ? HSYNC_POL : ~HSYNC_POL,
                  vsync_act ? VSYNC_POL : ~VSYNC_POL,
                  blank_next,
                  (h_reg == '0),
                  (h_reg == '0) && (v_reg == '0)};
  end

  // Output pipeline: every output goes through the same number of registers
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_STAGES; gi++) begin : g_pipe
      logic [PW-1:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
          if (!rst_n_in) stage_reg <= RST_VEC;
          else           stage_reg <= stage_next;
        end
      end else begin : g_next
        always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
          if (!rst_n_in) stage_reg <= RST_VEC;
          else           stage_reg <= g_pipe[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign {hcount_out, vcount_out, hsync_out, vsync_out, blank_out,
          line_start_out, frame_start_out} = g_pipe[PIPE_STAGES-1].stage_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Two instances share the clock, reset and
// config inputs: one with a single output stage, one with three. Frames are
// shrunk (15x8 default) so several frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HW = 11;
  localparam int VW = 10;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;   // 15 clocks per line
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;   // 8 lines per frame
  // {h=0, v=0, hsync=1, vsync=1, blank=1, ls=0, fs=0}
  localparam logic [31:0] RSTV = 32'h0000_001C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [HW-1:0] c_ha, c_hf, c_hs, c_hb;
  logic [VW-1:0] c_va, c_vf, c_vs, c_vb;
  logic          c_valid;

  logic          r1, e1, hs1, vs1, bl1, ls1, fs1;
  logic          r3, e3, hs3, vs3, bl3, ls3, fs3;
  logic [HW-1:0] h1, h3;
  logic [VW-1:0] v1, v3;
  logic [31:0]   d1_vec, d3_vec;

  assign d1_vec = {6'b0, h1, v1, hs1, vs1, bl1, ls1, fs1};
  assign d3_vec = {6'b0, h3, v3, hs3, vs3, bl3, ls3, fs3};

  vga_timing_gen #(
    .H_W(HW), .V_W(VW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_STAGES(1)
  ) dut1 (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .cfg_h_active_in(c_ha), .cfg_h_fp_in(c_hf), .cfg_h_sync_in(c_hs), .cfg_h_bp_in(c_hb),
    .cfg_v_active_in(c_va), .cfg_v_fp_in(c_vf), .cfg_v_sync_in(c_vs), .cfg_v_bp_in(c_vb),
    .cfg_valid_in(c_valid), .cfg_ready_out(r1), .cfg_err_out(e1),
    .hcount_out(h1), .vcount_out(v1), .hsync_out(hs1), .vsync_out(vs1),
    .blank_out(bl1), .line_start_out(ls1), .frame_start_out(fs1)
  );

  vga_timing_gen #(
    .H_W(HW), .V_W(VW),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_STAGES(3)
  ) dut3 (
    .pixel_clk_in(clk), .rst_n_in(rst_n),
    .cfg_h_active_in(c_ha), .cfg_h_fp_in(c_hf), .cfg_h_sync_in(c_hs), .cfg_h_bp_in(c_hb),
    .cfg_v_active_in(c_va), .cfg_v_fp_in(c_vf), .cfg_v_sync_in(c_vs), .cfg_v_bp_in(c_vb),
    .cfg_valid_in(c_valid), .cfg_ready_out(r3), .cfg_err_out(e3),
    .hcount_out(h3), .vcount_out(v3), .hsync_out(hs3), .vsync_out(vs3),
    .blank_out(bl3), .line_start_out(ls3), .frame_start_out(fs3)
  );

  int checks = 0;
  int errors = 0;

  // Expected timing: live set, pending set, expected counter state
  int t_ha, t_hf, t_hs, t_hb, t_va, t_vf, t_vs, t_vb;
  int n_ha, n_hf, n_hs, n_hb, n_va, n_vf, n_vs, n_vb;
  bit n_pend;
  bit offer_ok;
  bit exp_err;
  int rh, rv;
  logic [31:0] hist0, hist1, hist2;
  int step_idx, last_fs, last_period;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp_v, step_idx);
    end
  endtask

  function automatic logic [31:0] dec(input int h, input int v);
    logic hs_l, vs_l, bl;
    bl   = (h >= t_ha) || (v >= t_va);
    hs_l = (h >= t_ha + t_hf && h < t_ha + t_hf + t_hs) ? 1'b0 : 1'b1;
    vs_l = (v >= t_va + t_vf && v < t_va + t_vf + t_vs) ? 1'b0 : 1'b1;
    return {6'b0, h[HW-1:0], v[VW-1:0], hs_l, vs_l, bl, (h == 0), (h == 0 && v == 0)};
  endfunction

  function automatic int ht();
    return t_ha + t_hf + t_hs + t_hb;
  endfunction

  function automatic int vt();
    return t_va + t_vf + t_vs + t_vb;
  endfunction

  task automatic ref_reset();
    t_ha = HA; t_hf = HF; t_hs = HS; t_hb = HB;
    t_va = VA; t_vf = VF; t_vs = VS; t_vb = VB;
    n_pend = 0; exp_err = 0; rh = 0; rv = 0;
    hist0 = RSTV; hist1 = RSTV; hist2 = RSTV;
    last_fs = -1; last_period = 0;
  endtask

  // One clock: predict, advance one edge, compare at the falling edge
  task automatic step();
    logic [31:0] e;
    bit take;
    e = dec(rh, rv);
    hist2 = hist1; hist1 = hist0; hist0 = e;
    take = c_valid && !n_pend;
    if (rh == ht() - 1) begin
      rh = 0;
      if (rv == vt() - 1) begin
        rv = 0;
        if (n_pend) begin
          t_ha = n_ha; t_hf = n_hf; t_hs = n_hs; t_hb = n_hb;
          t_va = n_va; t_vf = n_vf; t_vs = n_vs; t_vb = n_vb;
          n_pend = 0;
        end
      end else rv++;
    end else rh++;
    if (take && offer_ok) begin
      n_pend = 1;
      n_ha = c_ha; n_hf = c_hf; n_hs = c_hs; n_hb = c_hb;
      n_va = c_va; n_vf = c_vf; n_vs = c_vs; n_vb = c_vb;
    end
    exp_err = take && !offer_ok;
    @(negedge clk);
    step_idx++;
    chk("vec_p1", d1_vec, e);
    chk("vec_p3", d3_vec, hist2);
    chk("ready_p1", {31'b0, r1}, {31'b0, !n_pend});
    chk("ready_p3", {31'b0, r3}, {31'b0, !n_pend});
    chk("err_p1", {31'b0, e1}, {31'b0, exp_err});
    chk("err_p3", {31'b0, e3}, {31'b0, exp_err});
    if (fs1 === 1'b1) begin
      if (last_fs >= 0) last_period = step_idx - last_fs;
      last_fs = step_idx;
    end
  endtask

  task automatic offer(input int ha, input int hf, input int hs, input int hb,
                       input int va, input int vf, input int vs, input int vb, input bit ok);
    c_ha = HW'(ha); c_hf = HW'(hf); c_hs = HW'(hs); c_hb = HW'(hb);
    c_va = VW'(va); c_vf = VW'(vf); c_vs = VW'(vs); c_vb = VW'(vb);
    offer_ok = ok;
    c_valid = 1'b1;
    step();
    c_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; c_valid = 1'b0; offer_ok = 1'b0;
    c_ha = '0; c_hf = '0; c_hs = '0; c_hb = '0;
    c_va = '0; c_vf = '0; c_vs = '0; c_vb = '0;
    step_idx = 0;
    ref_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_vec_p1", d1_vec, RSTV);
    chk("reset_vec_p3", d3_vec, RSTV);
    chk("reset_ready", {31'b0, r1}, 32'd1);
    chk("reset_err", {31'b0, e1}, 32'd0);

    // Defaults, two frames; latency 1 vs 3
    rst_n = 1'b1;
    step();
    chk("first_fs_p1", {31'b0, fs1}, 32'd1);
    chk("first_blank_p1", {31'b0, bl1}, 32'd0);
    chk("first_fs_p3_early", {31'b0, fs3}, 32'd0);
    step();
    step();
    chk("first_fs_p3", {31'b0, fs3}, 32'd1);
    for (int i = 0; i < 237; i++) step();
    chk("frame_period_default", last_period, 32'd120);

    // Mid-frame legal request (9x7 frame), offered at h=3 v=2
    for (int i = 0; i < 200 && !(rh == 3 && rv == 2); i++) step();
    offer(5, 1, 2, 1, 3, 1, 1, 2, 1'b1);
    chk("ready_drop", {31'b0, r1}, 32'd0);
    for (int i = 0; i < 200 && n_pend; i++) step();
    chk("ready_rise", {31'b0, r1}, 32'd1);
    chk("old_frame_period", last_period, 32'd120);
    for (int i = 0; i < 130; i++) step();
    chk("frame_period_new", last_period, 32'd63);

    // Illegal requests: h_sync=0, then h_total=2100 > 2048
    offer(5, 1, 0, 1, 3, 1, 1, 2, 1'b0);
    chk("err_hsync0", {31'b0, e1}, 32'd1);
    chk("ready_hsync0", {31'b0, r1}, 32'd1);
    step();
    chk("err_hsync0_clear", {31'b0, e1}, 32'd0);
    offer(2000, 50, 30, 20, 3, 1, 1, 2, 1'b0);
    chk("err_htotal", {31'b0, e1}, 32'd1);
    step();
    chk("err_htotal_clear", {31'b0, e1}, 32'd0);
    for (int i = 0; i < 70; i++) step();
    chk("frame_period_after_err", last_period, 32'd63);

    // Request on the wrap cycle: held for one more old-timing frame (6x4 next)
    for (int i = 0; i < 200 && !(rh == ht() - 1 && rv == vt() - 1); i++) step();
    offer(4, 0, 2, 0, 2, 1, 1, 0, 1'b1);
    chk("wrap_ready_drop", {31'b0, r1}, 32'd0);
    for (int i = 0; i < 200 && n_pend; i++) step();
    step();
    chk("held_frame_period", last_period, 32'd63);
    for (int i = 0; i < 30; i++) step();
    chk("frame_period_fp0", last_period, 32'd24);

    // Reset mid-frame with a request pending
    for (int i = 0; i < 100 && !(rh == 0 && rv == 0); i++) step();
    offer(3, 1, 1, 1, 2, 1, 1, 1, 1'b1);
    for (int i = 0; i < 100 && !(rh == 3 && rv == 2); i++) step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_vec_p1", d1_vec, RSTV);
    chk("async_rst_vec_p3", d3_vec, RSTV);
    chk("async_rst_ready", {31'b0, r1}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ref_reset();
    step();
    chk("rerun_fs_p1", {31'b0, fs1}, 32'd1);
    for (int i = 0; i < 239; i++) step();
    chk("frame_period_after_rst", last_period, 32'd120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
